// File: rtl/tc_sram_initiator_pkg.sv
// Shared types and helpers for the SRAM initiator and its response FIFO.
// Holds the FSM state encoding and the counter-width helper.
package tc_sram_initiator_pkg;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef enum logic [0:0] {
    INIT = ST_INIT,
    RUN  = ST_RUN
  } state_e;

  // Width needed to count 0..depth inclusive.
  function automatic int credit_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/tc_sram_rsp_fifo.sv
// Fall-through response FIFO. When it is empty, a pushed word is visible on
// head_o in the same cycle, and it can be popped in that cycle without being stored.
module tc_sram_rsp_fifo
  import tc_sram_initiator_pkg::*;
#(
  parameter int Depth = 2,
  parameter int Width = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            push_i,
  input  logic [Width-1:0]                push_data_i,
  input  logic                            pop_i,
  output logic [Width-1:0]                head_o,
  output logic                            full_o,
  output logic                            empty_o,
  output logic [credit_width(Depth)-1:0]  usage_o
);

  localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntWidth = credit_width(Depth);

  logic [Width-1:0]    r_mem [Depth];
  logic [PtrWidth-1:0] r_wr_ptr;
  logic [PtrWidth-1:0] r_rd_ptr;
  logic [CntWidth-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_bypass;
  logic w_wr;
  logic w_rd;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CntWidth'(Depth));
  // A word pushed and popped while empty never touches storage.
  assign w_bypass = w_empty & push_i & pop_i;
  assign w_wr     = push_i & ~w_bypass;
  assign w_rd     = pop_i & ~w_empty;

  always_ff @(posedge clk_i) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_rd) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      if (w_wr & ~w_rd) begin
        r_count <= r_count + 1'b1;
      end else if (w_rd & ~w_wr) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(push_i && w_full)) else $error("rsp fifo push while full");
    end
  end

  assign head_o  = w_empty ? push_data_i : r_mem[r_rd_ptr];
  assign full_o  = w_full;
  assign empty_o = w_empty;
  assign usage_o = r_count;

endmodule

// File: rtl/tc_sram_initiator.sv
// Valid/ready front end for a single-port fixed-latency SRAM. Reads are
// credit-limited so every issued read always has a response FIFO slot waiting.
module tc_sram_initiator
  import tc_sram_initiator_pkg::*;
#(
  parameter int                   NoWords     = 1024,
  parameter int                   DataWidth   = 32,
  parameter int                   ByteWidth   = 8,
  parameter int                   Latency     = 1,
  parameter int                   RspDepth    = Latency + 1,
  parameter bit                   InitOnReset = 1'b0,
  parameter logic [DataWidth-1:0] InitValue   = '0,
  parameter int                   BeWidth     = (DataWidth + ByteWidth - 1) / ByteWidth,
  parameter int                   AddrWidth   = (NoWords > 1) ? $clog2(NoWords) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic                 init_done_o,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [BeWidth-1:0]   req_be_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);

  localparam int CreditWidth = credit_width(RspDepth);

  state_e                 r_state;
  logic [AddrWidth-1:0]   r_fill_cnt;
  logic                   r_init_done;
  logic [Latency-1:0]     r_inflight;
  logic [CreditWidth-1:0] r_credits;

  logic                   w_in_init;
  logic                   w_req_ready;
  logic                   w_req_hs;
  logic                   w_rd_hs;
  logic [Latency-1:0]     w_inflight_next;
  logic                   w_push;
  logic                   w_rsp_valid;
  logic                   w_pop;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [CreditWidth-1:0] w_fifo_usage;

  assign w_in_init = (r_state == INIT);

  // Ready only looks at registered credits, so a pop frees its slot next cycle.
  assign w_req_ready = ~rst_i & ~w_in_init
                     & (req_we_i | (r_credits < CreditWidth'(RspDepth)));
  assign w_req_hs    = req_valid_i & w_req_ready;
  assign w_rd_hs     = w_req_hs & ~req_we_i;

  always_comb begin
    sram_req_o   = 1'b0;
    sram_we_o    = req_we_i;
    sram_addr_o  = req_addr_i;
    sram_wdata_o = req_wdata_i;
    sram_be_o    = req_be_i;
    if (rst_i) begin
      sram_req_o = 1'b0;
    end else if (w_in_init) begin
      sram_req_o   = 1'b1;
      sram_we_o    = 1'b1;
      sram_addr_o  = r_fill_cnt;
      sram_wdata_o = InitValue;
      sram_be_o    = '1;
    end else begin
      sram_req_o = w_req_hs;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= InitOnReset ? INIT : RUN;
      r_fill_cnt  <= '0;
      r_init_done <= ~InitOnReset;
    end else if (w_in_init) begin
      r_fill_cnt <= r_fill_cnt + 1'b1;
      if (r_fill_cnt == AddrWidth'(NoWords - 1)) begin
        r_state     <= RUN;
        r_init_done <= 1'b1;
      end
    end
  end

  // One bit per read in flight; the top bit marks sram_rdata_i as valid this cycle.
  for (genvar gi = 0; gi < Latency; gi++) begin : g_inflight
    if (gi == 0) begin : g_head
      assign w_inflight_next[gi] = w_rd_hs;
    end else begin : g_tail
      assign w_inflight_next[gi] = r_inflight[gi-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_inflight <= '0;
    end else begin
      r_inflight <= w_inflight_next;
    end
  end

  assign w_push      = r_inflight[Latency-1] & ~rst_i;
  assign w_rsp_valid = ~rst_i & (~w_fifo_empty | w_push);
  assign w_pop       = w_rsp_valid & rsp_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_credits <= '0;
    end else if (w_rd_hs & ~w_pop) begin
      r_credits <= r_credits + 1'b1;
    end else if (w_pop & ~w_rd_hs) begin
      r_credits <= r_credits - 1'b1;
    end
  end

  tc_sram_rsp_fifo #(
    .Depth (RspDepth),
    .Width (DataWidth)
  ) u_rsp_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (w_push),
    .push_data_i (sram_rdata_i),
    .pop_i       (w_pop),
    .head_o      (rsp_rdata_o),
    .full_o      (w_fifo_full),
    .empty_o     (w_fifo_empty),
    .usage_o     (w_fifo_usage)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (Latency >= 1 && RspDepth >= 1) else $error("bad Latency/RspDepth");
      if (w_req_hs) begin
        assert (32'(req_addr_i) < NoWords) else $error("request address out of range");
      end
      assert (!(w_push && w_fifo_full)) else $error("response push while full");
      assert (32'(w_fifo_usage) <= 32'(r_credits)) else $error("fifo usage exceeds credits");
    end
  end

  assign init_done_o = r_init_done;
  assign req_ready_o = w_req_ready;
  assign rsp_valid_o = w_rsp_valid;

endmodule

// File: tb/tb_tc_sram_initiator.sv
// Directed bench for tc_sram_initiator: fill, throughput, byte enables,
// backpressure, same-cycle push/pop and reset during reads.
module tb_tc_sram_initiator;

  localparam int NW  = 16;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam int DEP = 3;
  localparam int AW  = 4;
  localparam int BW  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          init_done;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [BW-1:0] req_be;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          sram_req;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [BW-1:0] sram_be;
  logic [DW-1:0] sram_rdata;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  tc_sram_initiator #(
    .NoWords     (NW),
    .DataWidth   (DW),
    .ByteWidth   (8),
    .Latency     (LAT),
    .RspDepth    (DEP),
    .InitOnReset (1'b1),
    .InitValue   (32'hDEADBEEF)
  ) u_dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .init_done_o  (init_done),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .req_be_i     (req_be),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_rdata_o  (rsp_rdata),
    .sram_req_o   (sram_req),
    .sram_we_o    (sram_we),
    .sram_addr_o  (sram_addr),
    .sram_wdata_o (sram_wdata),
    .sram_be_o    (sram_be),
    .sram_rdata_i (sram_rdata)
  );

  // SRAM macro model with byte enables and a LAT-cycle read pipeline.
  logic [DW-1:0] mem [NW];
  logic [DW-1:0] rd_pipe [LAT];

  always @(posedge clk) begin
    if (sram_req) begin
      if (sram_we) begin
        for (int b = 0; b < BW; b++) begin
          if (sram_be[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
        end
      end else begin
        rd_pipe[0] <= mem[sram_addr];
      end
    end
    for (int s = 1; s < LAT; s++) rd_pipe[s] <= rd_pipe[s-1];
  end
  assign sram_rdata = rd_pipe[LAT-1];

  always @(negedge clk) begin
    if (sram_req && !rst)
      $display("txn %s addr=%0d wdata=%h be=%b", sram_we ? "WR" : "RD", sram_addr, sram_wdata, sram_be);
    if (rsp_valid && rsp_ready)
      $display("rsp rdata=%h", rsp_rdata);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, drive the request/ready inputs, then check outputs mid-cycle.
  task automatic cyc(input string tag, input logic v, input logic we, input logic [3:0] a,
                     input logic [31:0] wd, input logic [3:0] be, input logic rr,
                     input logic exp_rdy, input logic exp_rv, input logic [31:0] exp_rd);
    @(posedge clk); #1;
    req_valid = v; req_we = we; req_addr = a; req_wdata = wd; req_be = be; rsp_ready = rr;
    #1;
    if (v) begin
      chk({tag, "_ready"}, req_ready, exp_rdy);
      chk({tag, "_sreq"}, sram_req, exp_rdy);
      if (exp_rdy) begin
        chk({tag, "_saddr"}, sram_addr, a);
        chk({tag, "_swe"}, sram_we, we);
      end
    end
    chk({tag, "_rspv"}, rsp_valid, exp_rv);
    if (exp_rv) chk({tag, "_rdata"}, rsp_rdata, exp_rd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1;
    #1;
    chk("rst_sram_req", sram_req, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_init_done", init_done, 0);

    // Fill: cycles 1..16 write InitValue to addr 0..15, ready held low.
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    for (int k = 0; k < NW; k++) begin
      if (k != 0) begin @(posedge clk); #2; end
      chk("fill_req", sram_req, 1);
      chk("fill_we", sram_we, 1);
      chk("fill_addr", sram_addr, k);
      chk("fill_wdata", sram_wdata, 32'hDEADBEEF);
      chk("fill_be", sram_be, 4'hF);
      chk("fill_ready", req_ready, 0);
      chk("fill_done", init_done, 0);
    end

    // Cycle 17: array usable; read addr 9.
    cyc("rd9", 1, 0, 9, 0, 0, 1, 1, 0, 0);
    chk("done_c17", init_done, 1);
    cyc("rd9_wait", 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc("rd9_data", 0, 0, 0, 0, 0, 1, 0, 1, 32'hDEADBEEF);

    // Throughput: 8 back-to-back reads, each answered 2 cycles after issue.
    cyc("wr3", 1, 1, 3, 32'h11223344, 4'hF, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++)
      cyc("thr", i < 8, 0, 3, 0, 0, 1, 1, i >= 2, 32'h11223344);
    cyc("thr_end", 0, 0, 0, 0, 0, 1, 0, 0, 0);

    // Byte enables on lanes 0 and 2 over 0xDEADBEEF.
    cyc("be_wr", 1, 1, 5, 32'hAABBCCDD, 4'b0101, 1, 1, 0, 0);
    cyc("be_rd", 1, 0, 5, 0, 0, 1, 1, 0, 0);
    cyc("be_wait", 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc("be_data", 0, 0, 0, 0, 0, 1, 0, 1, 32'hDEBBBEDD);

    cyc("wa0", 1, 1, 0, 32'h000000A0, 4'hF, 1, 1, 0, 0);
    cyc("wa1", 1, 1, 1, 32'h000000A1, 4'hF, 1, 1, 0, 0);
    cyc("wa2", 1, 1, 2, 32'h000000A2, 4'hF, 1, 1, 0, 0);

    // Backpressure: only 3 reads accepted, writes still flow.
    cyc("bp0", 1, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc("bp1", 1, 0, 1, 0, 0, 0, 1, 0, 0);
    cyc("bp2", 1, 0, 2, 0, 0, 0, 1, 1, 32'h000000A0);
    cyc("bp3", 1, 0, 3, 0, 0, 0, 0, 1, 32'h000000A0);
    cyc("bp4", 1, 0, 3, 0, 0, 0, 0, 1, 32'h000000A0);
    cyc("bp5", 1, 0, 3, 0, 0, 0, 0, 1, 32'h000000A0);
    cyc("bp_wr10", 1, 1, 10, 32'h00001010, 4'hF, 0, 1, 1, 32'h000000A0);
    cyc("bp_rel", 1, 0, 3, 0, 0, 1, 0, 1, 32'h000000A0);
    cyc("bp_res", 1, 0, 3, 0, 0, 1, 1, 1, 32'h000000A1);
    cyc("bp_d2", 0, 0, 0, 0, 0, 1, 0, 1, 32'h000000A2);
    cyc("bp_d3", 0, 0, 0, 0, 0, 1, 0, 1, 32'h11223344);
    cyc("bp_end", 0, 0, 0, 0, 0, 1, 0, 0, 0);

    // Same-cycle push/pop with 2 entries buffered: credits stay at 2.
    cyc("pp0", 1, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc("pp1", 1, 0, 1, 0, 0, 0, 1, 0, 0);
    cyc("pp_h0", 0, 0, 0, 0, 0, 0, 0, 1, 32'h000000A0);
    cyc("pp_h1", 0, 0, 0, 0, 0, 0, 0, 1, 32'h000000A0);
    cyc("pp_same", 1, 0, 2, 0, 0, 1, 1, 1, 32'h000000A0);
    cyc("pp_after", 1, 0, 3, 0, 0, 0, 1, 1, 32'h000000A1);
    cyc("pp_full", 1, 0, 0, 0, 0, 0, 0, 1, 32'h000000A1);
    cyc("pp_d1", 0, 0, 0, 0, 0, 1, 0, 1, 32'h000000A1);
    cyc("pp_d2", 0, 0, 0, 0, 0, 1, 0, 1, 32'h000000A2);
    cyc("pp_d3", 0, 0, 0, 0, 0, 1, 0, 1, 32'h11223344);
    cyc("pp_end", 0, 0, 0, 0, 0, 1, 0, 0, 0);

    // Reset with two reads in flight: nothing stale may emerge.
    cyc("rr0", 1, 0, 0, 0, 0, 1, 1, 0, 0);
    cyc("rr1", 1, 0, 1, 0, 0, 1, 1, 0, 0);
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b1;
    #1;
    chk("mid_rst_rspv", rsp_valid, 0);
    chk("mid_rst_sreq", sram_req, 0);
    chk("mid_rst_ready", req_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    for (int k = 0; k < NW; k++) begin
      if (k != 0) begin @(posedge clk); #2; end
      chk("refill_rspv", rsp_valid, 0);
      chk("refill_req", sram_req, 1);
      chk("refill_addr", sram_addr, k);
      chk("refill_ready", req_ready, 0);
    end
    cyc("post_rd0", 1, 0, 0, 0, 0, 1, 1, 0, 0);
    chk("post_done", init_done, 1);
    cyc("post_wait", 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc("post_data", 0, 0, 0, 0, 0, 1, 0, 1, 32'hDEADBEEF);
    cyc("post_end", 0, 0, 0, 0, 0, 1, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
